div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits in the EX stage beside the ALU.
- It is the producer side of the ALU-stall path. It raises o_stall toward the pipeline control logic while a division is in flight.
- It consumes that logic's EX hold and EX flush so it stays coherent with the pipeline.

Parameters:
- XLEN, 32, operand/result width; number of iteration cycles.

Ports:
- i_clk, input, 1, clock, rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_start, input, 1, EX holds a valid divide instruction; held high while EX is stalled.
- i_op, input, 2, funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_dividend, input, XLEN, rs1 value.
- i_divisor, input, XLEN, rs2 value.
- i_hold, input, 1, EX stage stalled by another source (cache stall); result must be held.
- i_flush, input, 1, EX stage flush; aborts any operation.
- o_stall, output, 1, ALU stall request to the control logic.
- o_result, output, XLEN, quotient or remainder; valid while state is DONE.
- o_valid, output, 1, o_result valid (state==DONE).

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE; o_result=0; o_valid=0; iteration counter=0; internal quotient/remainder/operand registers=0.
  - o_stall=0, unless i_start is asserted after reset release.
- States: IDLE, CALC, DONE.
- o_stall (combinational) = (IDLE && i_start) || CALC. It is not gated by i_flush.
- IDLE, i_start=1, i_flush=0: latch operands, op, and sign info.
  - Signed ops use absolute values.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - Special cases go straight to DONE with the result registered:
    - Divisor==0: quotient=all ones, remainder=dividend.
    - Signed ops with dividend==MIN and divisor==-1: quotient=MIN, remainder=0.
  - Otherwise go to CALC with counter=XLEN.
- CALC: one restoring step per cycle.
  - rem = {rem[XLEN-2:0], q[XLEN-1]}; q shifts left.
  - If rem >= divisor: subtract and set q[0]=1.
  - Counter decrements; when it reaches 0 go to DONE.
  - On the DONE transition, register the sign-corrected selected result (two's complement negate).
- Latency:
  - Normal op stalls 1+XLEN cycles (33); o_valid first rises in the cycle o_stall falls.
  - Special case stalls 1 cycle.
- DONE: o_stall=0, o_valid=1.
  - i_hold=1: stay in DONE, o_result stable. i_start is still high but must not restart the operation.
  - i_hold=0: return to IDLE next cycle (the instruction advances).
- i_flush=1 in any state → IDLE next cycle; partial results are discarded. i_start in the same cycle is ignored.
- i_hold during CALC has no effect; iteration continues.
- The internal remainder register is XLEN+1 bits wide, so comparison is unsigned without overflow.
- DIVU/REMU treat operands as unsigned; no negation.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- Defined:
  - Keep the last completed {dividend, divisor, signedness, quotient, remainder} plus a valid bit.
  - The valid bit is cleared on reset only; flush does not clear it; it is updated only on normal completion in DONE.
  - IDLE start with a tag match → DONE in 1 stall cycle, returning the cached quotient or remainder per i_op. This lets a DIV followed by a REM on the same operands cost 1 cycle.
- Not defined: no tag storage; every non-special op takes 33 stall cycles.

Decomposition:
- Package div_pkg:
  - div_op_t enum (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11).
  - div_state_t enum (IDLE, CALC, DONE).
  - Helper functions is_signed(op) and is_rem(op).
- Sub-module div_step: combinational single restoring iteration (rem_in, q_in, divisor → rem_out, q_out).
- Top: FSM, counter, sign fix-up, optional cache.

Test Plan:
- DIV 100/7, i_hold=0 → o_stall high exactly 33 cycles, then o_result=14 with o_valid=1 for 1 cycle, then IDLE.
- REM -7 (0xFFFFFFF9) by 2 → 0xFFFFFFFF (-1). DIVU 0xFFFFFFFE/3 → 0x55555554.
- DIVU 5/0 → 0xFFFFFFFF after 1 stall cycle. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, each with 1 stall cycle.
- i_flush at cycle 10 of CALC → IDLE next cycle, o_stall=0. A following DIV 9/3 → 3 after 33 stall cycles.
- i_hold=1 for 5 cycles entering DONE with i_start=1 → o_result stable and o_stall=0 throughout, no restart. i_hold release → IDLE.
- With DIV_RESULT_CACHE_EN: DIV 1000/7 (33 cycles, 142), then REM 1000/7 → 6 after 1 stall cycle. Without the macro the REM takes 33 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and op decode helpers for the iterative RV32M divider.
package div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_t;

   function automatic logic is_signed(input div_op_t op);
      return ~op[0];
   endfunction

   function automatic logic is_rem(input div_op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   i_rem,
   input  logic [XLEN-1:0] i_q,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN:0]   o_rem,
   output logic [XLEN-1:0] o_q
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;
   logic          w_ge;

   assign w_shift = {i_rem[XLEN-1:0], i_q[XLEN-1]};
   // A set top bit means the shifted value is at least 2^XLEN, which always exceeds the divisor.
   assign w_ge    = i_rem[XLEN] | (w_shift >= {1'b0, i_divisor});
   assign w_diff  = w_shift - {1'b0, i_divisor};
   assign o_rem   = w_ge ? w_diff : w_shift;
   assign o_q     = {i_q[XLEN-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// EX-stage radix-2 restoring divider for DIV/DIVU/REM/REMU with pipeline stall/hold/flush handshake.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_unit
   import div_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   input  logic            i_hold,
   input  logic            i_flush,
   output logic            o_stall,
   output logic [XLEN-1:0] o_result,
   output logic            o_valid
);

   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN:0]   r_rem;
   logic [XLEN-1:0] r_q;
   logic [XLEN-1:0] r_divisor;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_is_rem;
   logic [XLEN-1:0] r_result;

   div_op_t         w_op;
   logic            w_signed;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_div_zero;
   logic            w_ovf;
   logic [XLEN-1:0] w_spec_res;
   logic [XLEN:0]   w_rem_nx;
   logic [XLEN-1:0] w_q_nx;
   logic [XLEN-1:0] w_q_fin;
   logic [XLEN-1:0] w_r_fin;
   logic            w_last;
   logic            w_hit;
   logic [XLEN-1:0] w_hit_res;

   assign w_op       = div_op_t'(i_op);
   assign w_signed   = is_signed(w_op);
   assign w_a_neg    = w_signed & i_dividend[XLEN-1];
   assign w_b_neg    = w_signed & i_divisor[XLEN-1];
   assign w_abs_a    = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
   assign w_abs_b    = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;
   assign w_div_zero = (i_divisor == '0);
   assign w_ovf      = w_signed && (i_dividend == MIN_VAL) && (i_divisor == '1);
   // Divide-by-zero and MIN/-1 bypass the iteration with their architecturally defined results.
   assign w_spec_res = w_div_zero ? (is_rem(w_op) ? i_dividend : '1)
                                  : (is_rem(w_op) ? '0 : i_dividend);

   div_step #(.XLEN(XLEN)) u_step (
      .i_rem     (r_rem),
      .i_q       (r_q),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_nx),
      .o_q       (w_q_nx)
   );

   assign w_q_fin = r_neg_q ? (~w_q_nx + 1'b1) : w_q_nx;
   assign w_r_fin = r_neg_r ? (~w_rem_nx[XLEN-1:0] + 1'b1) : w_rem_nx[XLEN-1:0];
   assign w_last  = (r_state == CALC) && (r_cnt == CNT_W'(1));

`ifdef DIV_RESULT_CACHE_EN
   logic            r_c_valid;
   logic [XLEN-1:0] r_c_a;
   logic [XLEN-1:0] r_c_b;
   logic            r_c_signed;
   logic [XLEN-1:0] r_c_q;
   logic [XLEN-1:0] r_c_r;
   logic [XLEN-1:0] r_p_a;
   logic [XLEN-1:0] r_p_b;
   logic            r_p_signed;

   assign w_hit     = r_c_valid && (r_c_a == i_dividend) && (r_c_b == i_divisor) &&
                      (r_c_signed == w_signed);
   assign w_hit_res = is_rem(w_op) ? r_c_r : r_c_q;

   // Tags are captured at start and committed only when an iteration runs to completion.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_c_valid  <= 1'b0;
         r_c_a      <= '0;
         r_c_b      <= '0;
         r_c_signed <= 1'b0;
         r_c_q      <= '0;
         r_c_r      <= '0;
         r_p_a      <= '0;
         r_p_b      <= '0;
         r_p_signed <= 1'b0;
      end else if (!i_flush) begin
         if (r_state == IDLE && i_start) begin
            r_p_a      <= i_dividend;
            r_p_b      <= i_divisor;
            r_p_signed <= w_signed;
         end
         if (w_last) begin
            r_c_valid  <= 1'b1;
            r_c_a      <= r_p_a;
            r_c_b      <= r_p_b;
            r_c_signed <= r_p_signed;
            r_c_q      <= w_q_fin;
            r_c_r      <= w_r_fin;
         end
      end
   end
`else
   assign w_hit     = 1'b0;
   assign w_hit_res = '0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_q       <= '0;
         r_divisor <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_is_rem  <= 1'b0;
         r_result  <= '0;
      end else if (i_flush) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_is_rem <= is_rem(w_op);
                  if (w_div_zero || w_ovf) begin
                     r_result <= w_spec_res;
                     r_state  <= DONE;
                  end else if (w_hit) begin
                     r_result <= w_hit_res;
                     r_state  <= DONE;
                  end else begin
                     r_rem     <= '0;
                     r_q       <= w_abs_a;
                     r_divisor <= w_abs_b;
                     r_neg_q   <= w_a_neg ^ w_b_neg;
                     r_neg_r   <= w_a_neg;
                     r_cnt     <= CNT_W'(XLEN);
                     r_state   <= CALC;
                  end
               end
            end
            CALC: begin
               r_rem <= w_rem_nx;
               r_q   <= w_q_nx;
               r_cnt <= r_cnt - 1'b1;
               if (w_last) begin
                  r_result <= r_is_rem ? w_r_fin : w_q_fin;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               // The instruction stays in EX while held, so i_start must not relaunch it.
               if (!i_hold) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_stall  = ((r_state == IDLE) && i_start) || (r_state == CALC);
   assign o_valid  = (r_state == DONE);
   assign o_result = r_result;

endmodule
